// File: rtl/fp_accum.sv
// Sequential IEEE-754 single-precision window accumulator: align, add, then
// normalise one bit per clock; emits the sum of every N_TERMS accepted terms.
module fp_accum #(
  parameter int unsigned N_TERMS = 9,
  parameter int unsigned CNT_W   = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ALIGN = 3'd1,
    S_ADD   = 3'd2,
    S_NORM  = 3'd3,
    S_STEP  = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t             state_r,     state_s;
  logic [31:0]        term_r,      term_s;
  logic [31:0]        acc_r,       acc_s;
  logic               a_sign_r,    a_sign_s;
  logic               b_sign_r,    b_sign_s;
  logic [23:0]        a_frac_r,    a_frac_s;
  logic [23:0]        b_frac_r,    b_frac_s;
  logic [7:0]         w_exp_r,     w_exp_s;
  logic [CNT_W-1:0]   count_r,     count_s;
  logic [31:0]        out_data_r,  out_data_s;
  logic               out_valid_r, out_valid_s;
  logic               in_ready_r,  in_ready_s;
  logic               busy_r,      busy_s;

  logic [7:0]         t_exp_s, c_exp_s, exp_diff_s, exp_dec_s;
  logic [23:0]        t_frac_s, c_frac_s, small_frac_s, shl_s;
  logic               term_big_s;
  logic [24:0]        sum_s;

  // Operand decode and arithmetic shared by the FSM states.
  always_comb begin
    t_exp_s      = term_r[30:23];
    c_exp_s      = acc_r[30:23];
    t_frac_s     = {1'b1, term_r[22:0]};
    c_frac_s     = {1'b1, acc_r[22:0]};
    term_big_s   = (t_exp_s > c_exp_s);
    exp_diff_s   = term_big_s ? (t_exp_s - c_exp_s) : (c_exp_s - t_exp_s);
    small_frac_s = term_big_s ? c_frac_s : t_frac_s;
    sum_s        = {1'b0, a_frac_r} + {1'b0, b_frac_r};
    shl_s        = {a_frac_r[22:0], 1'b0};
    exp_dec_s    = w_exp_r - 8'd1;
  end

  // Next-state and datapath update for every FSM state.
  always_comb begin
    state_s     = state_r;
    term_s      = term_r;
    acc_s       = acc_r;
    a_sign_s    = a_sign_r;
    b_sign_s    = b_sign_r;
    a_frac_s    = a_frac_r;
    b_frac_s    = b_frac_r;
    w_exp_s     = w_exp_r;
    count_s     = count_r;
    out_data_s  = out_data_r;
    out_valid_s = out_valid_r;
    case (state_r)
      S_IDLE: begin
        if (in_valid && in_ready_r) begin
          term_s  = in_data;
          state_s = S_ALIGN;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_ALIGN: begin
        // Zero terms and an already saturated acc leave the sum unchanged.
        if (t_exp_s == 8'd0 || c_exp_s == 8'hFF) begin
          state_s = S_STEP;
        end else if (t_exp_s == 8'hFF) begin
          acc_s   = {term_r[31], 8'hFF, 23'd0};
          state_s = S_STEP;
        end else if (c_exp_s == 8'd0) begin
          acc_s   = term_r;
          state_s = S_STEP;
        end else begin
          a_sign_s = term_big_s ? term_r[31] : acc_r[31];
          b_sign_s = term_big_s ? acc_r[31]  : term_r[31];
          a_frac_s = term_big_s ? t_frac_s   : c_frac_s;
          w_exp_s  = term_big_s ? t_exp_s    : c_exp_s;
          b_frac_s = (exp_diff_s >= 8'd24) ? 24'd0 : (small_frac_s >> exp_diff_s);
          state_s  = S_ADD;
        end
      end
      S_ADD: begin
        if (a_sign_r == b_sign_r) begin
          if (sum_s[24]) begin
            if (w_exp_r == 8'hFE) begin
              acc_s   = {a_sign_r, 8'hFF, 23'd0};
              state_s = S_STEP;
            end else begin
              a_frac_s = sum_s[24:1];
              w_exp_s  = w_exp_r + 8'd1;
              state_s  = S_NORM;
            end
          end else begin
            a_frac_s = sum_s[23:0];
            state_s  = S_NORM;
          end
        end else if (a_frac_r == b_frac_r) begin
          acc_s   = 32'd0;
          state_s = S_STEP;
        end else if (a_frac_r > b_frac_r) begin
          a_frac_s = a_frac_r - b_frac_r;
          state_s  = S_NORM;
        end else begin
          a_frac_s = b_frac_r - a_frac_r;
          a_sign_s = b_sign_r;
          state_s  = S_NORM;
        end
      end
      S_NORM: begin
        // Pack in the same cycle as the final shift, so k shifts take k cycles.
        if (a_frac_r[23]) begin
          acc_s   = {a_sign_r, w_exp_r, a_frac_r[22:0]};
          state_s = S_STEP;
        end else if (w_exp_r == 8'd1) begin
          acc_s   = 32'd0;
          state_s = S_STEP;
        end else begin
          a_frac_s = shl_s;
          w_exp_s  = exp_dec_s;
          if (shl_s[23]) begin
            acc_s   = {a_sign_r, exp_dec_s, shl_s[22:0]};
            state_s = S_STEP;
          end else begin
            state_s = S_NORM;
          end
        end
      end
      S_STEP: begin
        count_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        if (count_s == CNT_W'(N_TERMS)) begin
          out_data_s  = acc_r;
          out_valid_s = 1'b1;
          state_s     = S_OUT;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_s = 1'b0;
          acc_s       = 32'd0;
          count_s     = {CNT_W{1'b0}};
          state_s     = S_IDLE;
        end else begin
          state_s = S_OUT;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
    in_ready_s = (state_s == S_IDLE);
    busy_s     = (state_s != S_IDLE);
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= S_IDLE;
      term_r      <= 32'd0;
      acc_r       <= 32'd0;
      a_sign_r    <= 1'b0;
      b_sign_r    <= 1'b0;
      a_frac_r    <= 24'd0;
      b_frac_r    <= 24'd0;
      w_exp_r     <= 8'd0;
      count_r     <= {CNT_W{1'b0}};
      out_data_r  <= 32'd0;
      out_valid_r <= 1'b0;
      in_ready_r  <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      term_r      <= term_s;
      acc_r       <= acc_s;
      a_sign_r    <= a_sign_s;
      b_sign_r    <= b_sign_s;
      a_frac_r    <= a_frac_s;
      b_frac_r    <= b_frac_s;
      w_exp_r     <= w_exp_s;
      count_r     <= count_s;
      out_data_r  <= out_data_s;
      out_valid_r <= out_valid_s;
      in_ready_r  <= in_ready_s;
      busy_r      <= busy_s;
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign busy      = busy_r;

endmodule
